// File: rtl/spi_host_arbiter.sv
// spi_host_arbiter: round-robin bus master for the SPI register file.
// Grants one of two requesters, sends one frame (address LSB first, op bit,
// data LSB first), captures read data from spi_miso and pulses the
// requester's ack for one cycle with rdata.
// Ports:
//   reset, sclk            async active-high reset, system clock
//   req/we/addr/wdata[01]  requester inputs (sampled at grant)
//   ack0, ack1, rdata      one-cycle completion pulse and read data
//   busy                   high from grant until return to IDLE
//   spi_cs/sclk/mosi/miso  register-file serial pins (outputs registered)
module spi_host_arbiter #(
  parameter int unsigned num_addrbits = 3,
  parameter int unsigned num_databits = 8
) (
  input  logic                    reset,
  input  logic                    sclk,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [num_addrbits-1:0] addr0,
  input  logic [num_addrbits-1:0] addr1,
  input  logic [num_databits-1:0] wdata0,
  input  logic [num_databits-1:0] wdata1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [num_databits-1:0] rdata,
  output logic                    busy,
  output logic                    spi_cs,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);

  localparam int unsigned FL       = num_addrbits + 1 + num_databits;
  localparam int unsigned CW       = $clog2(FL + 1);
  // zero-based index of the first data bit period (sampling starts here)
  localparam int unsigned FIRST_RD = num_addrbits + 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t                  state;
  logic                    last;
  logic                    owner;
  logic                    is_write;
  logic [FL-1:0]           shreg;
  logic [num_databits-1:0] cap;
  logic [CW-1:0]           bit_cnt;

  logic                    grant_any_c;
  logic                    grant1_c;
  logic                    grant_we_c;
  logic [FL-1:0]           frame_c;

  // Round-robin pick and frame assembly; read frames carry zero data bits.
  always_comb begin
    grant_any_c = req0 | req1;
    grant1_c    = req1 & (~req0 | ~last);
    grant_we_c  = grant1_c ? we1 : we0;
    frame_c     = '0;
    if (grant1_c)
      frame_c = {({num_databits{we1}} & wdata1), we1, addr1};
    else
      frame_c = {({num_databits{we0}} & wdata0), we0, addr0};
  end

  // Frame sequencer with registered pin and handshake outputs.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      is_write <= 1'b0;
      shreg    <= '0;
      cap      <= '0;
      bit_cnt  <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      spi_cs   <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_any_c) begin
            owner    <= grant1_c;
            last     <= grant1_c;
            is_write <= grant_we_c;
            spi_cs   <= 1'b1;
            spi_sclk <= 1'b0;
            busy     <= 1'b1;
            spi_mosi <= frame_c[0];
            shreg    <= frame_c >> 1;
            bit_cnt  <= '0;
            cap      <= '0;
            state    <= SETUP;
          end
        end
        SETUP: state <= SHIFT;
        SHIFT: begin
          if (!spi_sclk) begin
            spi_sclk <= 1'b1;
          end else begin
            // End of a high phase: sample data bits, then advance mosi
            spi_sclk <= 1'b0;
            if (bit_cnt >= CW'(FIRST_RD))
              cap <= {spi_miso, cap[num_databits-1:1]};
            if (bit_cnt == CW'(FL - 1)) begin
              spi_mosi <= 1'b0;
              state    <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt + CW'(1);
              spi_mosi <= shreg[0];
              shreg    <= shreg >> 1;
            end
          end
        end
        HOLD: begin
          spi_cs <= 1'b0;
          ack0   <= ~owner;
          ack1   <= owner;
          rdata  <= is_write ? '0 : cap;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          rdata <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_arbiter.sv
// Scoreboard bench for spi_host_arbiter with a behavioural SPI register file.
module tb_spi_host_arbiter;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned FL = AW + 1 + DW;

  logic          sclk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata;
  logic          busy, spi_cs, spi_sclk, spi_mosi;
  logic          spi_miso = 1'b0;

  always #5 sclk = ~sclk;

  spi_host_arbiter #(.num_addrbits(AW), .num_databits(DW)) dut (
    .reset(reset), .sclk(sclk),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- register-file slave model ----------------
  logic [DW-1:0] regs [8];
  logic [FL-1:0] s_cap = '0;
  logic [DW-1:0] s_rd  = '0;
  logic [DW-1:0] s_tmp;
  int            bitn  = 0;

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    regs[0] = 8'h3C;
    regs[2] = 8'h11;
  end

  // Capture mosi on each rise; commit a write only after the full frame.
  always @(posedge spi_sclk or negedge spi_cs) begin
    if (!spi_cs) begin
      bitn = 0;
    end else if (bitn < FL) begin
      s_cap[bitn] = spi_mosi;
      bitn++;
      if (bitn == FL && s_cap[AW] && s_cap[AW-1:0] != 3'd7)
        regs[s_cap[AW-1:0]] = s_cap[FL-1:AW+1];
    end
  end

  // Drive read data on falling edges after the op bit.
  always @(negedge spi_sclk) begin
    if (spi_cs) begin
      if (bitn == AW + 1) begin
        s_tmp = (!s_cap[AW] && s_cap[AW-1:0] != 3'd7) ? regs[s_cap[AW-1:0]] : 8'h00;
        spi_miso <= s_tmp[0];
        s_rd     <= s_tmp >> 1;
      end else if (bitn > AW + 1 && bitn < FL) begin
        spi_miso <= s_rd[0];
        s_rd     <= s_rd >> 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          id;
    logic [DW-1:0] rdata;
    logic [FL-1:0] frame;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  function automatic void push(input logic id, input logic [DW-1:0] rd, input logic [FL-1:0] fr);
    exp_t x;
    x.id = id; x.rdata = rd; x.frame = fr;
    sbq.push_back(x);
  endfunction

  int   ack_cnt     = 0;
  int   cs_rise_cyc = 0;
  int   cs_len      = 0;
  int   rises       = 0;
  int   gap         = 0;
  logic gap_valid   = 1'b0;
  logic cs_prev     = 1'b0;
  logic sclk_prev   = 1'b0;
  logic ack_prev    = 1'b0;

  // Monitor: frame shape on spi_cs, and ack responses against the queue.
  always @(negedge sclk) begin
    if (reset) begin
      gap_valid = 1'b0;
      gap       = 0;
    end else begin
      if (spi_cs && !cs_prev) begin
        cs_rise_cyc = cyc;
        cs_len      = 0;
        rises       = 0;
        if (gap_valid) check("cs_gap_ge2", 32'(gap >= 2), 1);
      end
      if (spi_cs) begin
        cs_len++;
        if (spi_sclk && !sclk_prev) rises++;
      end else begin
        gap++;
      end
      if (!spi_cs && cs_prev) begin
        check("cs_high_cycles", cs_len, 26);
        check("sclk_rises", rises, FL);
        gap       = 1;
        gap_valid = 1'b1;
      end
    end
    if (ack_prev) check("ack_pulse_width", 32'(ack0 | ack1), 0);
    if (ack0 | ack1) begin
      ack_cnt++;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: ack0=%b ack1=%b with nothing expected", ack0, ack1);
      end else begin
        e = sbq.pop_front();
        check("ack_id", {30'd0, ack1, ack0}, e.id ? 32'd2 : 32'd1);
        check("rdata", rdata, e.rdata);
        check("mosi_frame", s_cap, e.frame);
        check("ack_latency", cyc - cs_rise_cyc, 26);
      end
    end
    ack_prev  = ack0 | ack1;
    cs_prev   = spi_cs;
    sclk_prev = spi_sclk;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ack(input int target);
    for (int i = 0; i < 80; i++) begin
      @(negedge sclk); #1;
      if (ack_cnt >= target) return;
    end
    check("timeout_ack", ack_cnt, target);
  endtask

  task automatic wait_cs();
    for (int i = 0; i < 50; i++) begin
      @(negedge sclk); #1;
      if (spi_cs) return;
    end
    check("timeout_cs", 0, 1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge sclk);
    #1;
    check("rst_cs", spi_cs, 0);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    @(negedge sclk); #1 reset = 1'b0;
    repeat (2) @(negedge sclk);

    // Write 0xA5 to addr 1 from requester 0
    push(1'b0, 8'h00, 12'hA59);
    req0 = 1; we0 = 1; addr0 = 3'd1; wdata0 = 8'hA5;
    wait_cs();
    check("busy_in_frame", busy, 1);
    wait_ack(1);
    req0 = 0;
    @(negedge sclk); #1;
    check("busy_after_done", busy, 0);
    check("ack_cleared", {ack1, ack0}, 0);
    check("slave_wrote_a5", regs[1], 8'hA5);
    repeat (3) @(negedge sclk);

    // Read addr 1 from requester 0
    push(1'b0, 8'hA5, 12'h001);
    #1 req0 = 1; we0 = 0; addr0 = 3'd1;
    wait_ack(2);
    req0 = 0;
    repeat (3) @(negedge sclk);

    // Requester 1 reads addr 0, drops req 5 cycles after grant
    push(1'b1, 8'h3C, 12'h000);
    #1 req1 = 1; we1 = 0; addr1 = 3'd0;
    wait_cs();
    repeat (5) @(negedge sclk);
    #1 req1 = 0;
    check("busy_after_drop", busy, 1);
    check("cs_after_drop", spi_cs, 1);
    wait_ack(3);
    repeat (3) @(negedge sclk);

    // Both requesters held: grants alternate 0,1,0,1
    push(1'b0, 8'h00, 12'h5AB);
    push(1'b1, 8'hA5, 12'h001);
    push(1'b0, 8'h00, 12'h5AB);
    push(1'b1, 8'hA5, 12'h001);
    #1;
    req0 = 1; we0 = 1; addr0 = 3'd3; wdata0 = 8'h5A;
    req1 = 1; we1 = 0; addr1 = 3'd1;
    wait_ack(4);
    wait_ack(5);
    wait_ack(6);
    wait_ack(7);
    req0 = 0; req1 = 0;
    check("slave_wrote_5a", regs[3], 8'h5A);
    repeat (3) @(negedge sclk);

    // Reset mid-frame during a write of 0xFF to addr 2
    #1 req0 = 1; we0 = 1; addr0 = 3'd2; wdata0 = 8'hFF;
    wait_cs();
    repeat (10) @(posedge sclk);
    #1 reset = 1'b1;
    req0 = 0;
    #1;
    check("abort_cs", spi_cs, 0);
    check("abort_sclk", spi_sclk, 0);
    check("abort_mosi", spi_mosi, 0);
    check("abort_ack", {ack1, ack0}, 0);
    check("abort_busy", busy, 0);
    check("ctrl1_unchanged", regs[2], 8'h11);

    // Tie after reset: requester 0 first (read unused addr 7), then 1
    push(1'b0, 8'h00, 12'h007);
    push(1'b1, 8'h3C, 12'h000);
    req0 = 1; we0 = 0; addr0 = 3'd7;
    req1 = 1; we1 = 0; addr1 = 3'd0;
    repeat (2) @(negedge sclk);
    #1 reset = 1'b0;
    wait_ack(8);
    req0 = 0;
    wait_ack(9);
    req1 = 0;

    repeat (40) @(negedge sclk);
    #1;
    check("sb_drained", sbq.size(), 0);
    check("final_idle_busy", busy, 0);
    check("final_idle_cs", spi_cs, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_host_arbiter.md
# spi_host_arbiter

Bus-side master for the SPI register file. It arbitrates between two on-chip requesters, serialises each granted access into one SPI frame (address, op, data), and returns read data with a one-cycle acknowledge. It sits between the system logic and the register file's `cs`/`sclk`/`din`/`dout` pins and is the only driver of those pins.

## Interface
- num_addrbits, 3, register address width; must match the register file.
- num_databits, 8, register data width; must match the register file.
- reset  in  1  asynchronous, active-high.
- sclk  in  1  system clock; every register in this block is rising-edge `sclk`.
- req0 / req1  in  1  level request; held until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read; sampled at grant.
- addr0 / addr1  in  num_addrbits  register address; sampled at grant.
- wdata0 / wdata1  in  num_databits  write data; sampled at grant.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata  out  num_databits  read data; valid while ack0 or ack1 is high.
- busy  out  1  high from grant until return to IDLE.
- spi_cs  out  1  frame enable, active-high.
- spi_sclk  out  1  serial clock, idle low.
- spi_mosi  out  1  serial data to slave.
- spi_miso  in  1  serial data from slave.

## Operation
- Frame length `FL = num_addrbits + 1 + num_databits` bit periods (12 by default).
- Bit order: address LSB first, then op bit (1 = write, 0 = read), then data LSB first.
  - Write frames drive wdata on mosi.
  - Read frames drive mosi = 0 during the data bits.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE: if any req is high, grant, latch we/addr/wdata into the shift register, set spi_cs = 1, go to SETUP.
- SETUP: 1 cycle, spi_sclk = 0, mosi = bit 0. Then go to SHIFT.
- SHIFT: 2·FL cycles, alternating low-phase and high-phase cycles.
  - Low-phase cycle: spi_sclk = 0, mosi = bit k.
  - High-phase cycle: spi_sclk = 1.
  - A bit-period counter advances on each high→low transition.
- Sampling: on the edge that ends the high phase of bit period k (1-based), for `k = num_addrbits+2 … FL`, shift spi_miso into rdata LSB first. That is bit periods 5..12 by default.
- HOLD: 1 cycle, spi_cs = 1, spi_sclk = 0.
- DONE: 1 cycle, spi_cs = 0, ack of the granted requester = 1.
  - rdata is the captured value for a read and 0 for a write.
  - Then go to IDLE.
- Arbitration is round-robin. A `last` register records the last granted requester.
  - With both requests high, the requester that is not `last` wins.
  - With one request high, it wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- req is sampled only in IDLE. If a requester drops req mid-frame, the frame still completes and ack still pulses.
- spi_mosi, spi_sclk and spi_cs are registered outputs with no combinational path from inputs.

## Timing
- Reset values: spi_cs = 0, spi_sclk = 0, spi_mosi = 0, ack0 = ack1 = 0, rdata = 0, busy = 0, state IDLE, last = 1, counters 0.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously) and no ack is issued. The slave sees cs fall and aborts; no partial write can occur because the data is not yet complete.
- Grant at edge N:
  - spi_cs = 1 from N.
  - First spi_sclk rise at N+2.
  - Last spi_sclk fall at N+25.
  - spi_cs = 0 and ack = 1 from N+26.
  - ack = 0 at N+27 (default parameters).
  - General form: ack at N + 2·FL + 2.
- Next grant no earlier than edge N+28, so spi_cs is low for at least 2 cycles between frames.
- mosi changes only on the same edge that drives spi_sclk low (or enters SETUP), giving half a period of setup and hold around each spi_sclk rise.
- The slave updates dout on spi_sclk falling; it is sampled one sclk cycle later, on the next high→low edge.
- busy = 1 from N to N+27.

## Test plan
- req0 write, addr 1, wdata 0xA5: mosi across bit periods 1..12 = 1,0,0,1,1,0,1,0,0,1,0,1; ack0 pulses once at N+26; rdata = 0; ack1 stays 0.
- req0 read, addr 1, against a register-file model that already holds 0xA5: mosi bit 4 = 0; rdata = 0xA5 while ack0 is high.
- req0 and req1 both held continuously, with different addresses: grants alternate 0,1,0,1; each frame is 26 cycles of spi_cs high with spi_cs low for at least 2 cycles between frames; exactly 12 spi_sclk rises per frame.
- req1 read, addr 0, with slave stat0 = 0x3C: rdata = 0x3C with ack1; req1 deasserted 5 cycles after grant, yet the frame completes and ack1 still pulses.
- reset asserted at N+10 during a write of 0xFF to addr 2: spi_cs, spi_sclk, spi_mosi and ack go to 0 immediately; slave ctrl1 is unchanged; after reset release with req0 and req1 both high, requester 0 is granted first.
- Read of unused addr 7: rdata = 0x00 with ack; the frame is otherwise identical to any other read.
